// File: rtl/wrbuf_pkg.sv
// Shared constants and types for the cache write-buffer controller.
package wrbuf_pkg;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 64;

    localparam logic [1:0] SEL_D0   = 2'b00;
    localparam logic [1:0] SEL_D1   = 2'b01;
    localparam logic [1:0] SEL_D2   = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} drain_state_t;

    // Next source index modulo 3.
    function automatic logic [1:0] rr_next(input logic [1:0] i);
        return (i == SEL_D2) ? SEL_D0 : i + 2'd1;
    endfunction
endpackage

// File: rtl/wrbuf_rr_arb.sv
// 3-way round-robin arbiter; priority last+1, last+2, last. Grant/sel are combinational.
module wrbuf_rr_arb
    import wrbuf_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req,
    input  logic       en,
    output logic [2:0] grant,
    output logic [1:0] sel
);
    logic [1:0] last, p0, p1;
    logic [3:0] req_x;

    always_comb begin
        req_x = {1'b0, req};
        p0    = rr_next(last);
        p1    = rr_next(p0);
        sel   = SEL_IDLE;
        if (en) begin
            if (req_x[p0])        sel = p0;
            else if (req_x[p1])   sel = p1;
            else if (req_x[last]) sel = last;
        end
        grant = (sel == SEL_IDLE) ? 3'b000 : 3'(3'b001 << sel);
    end

    // Reset to d2 so d0 is first in line.
    always_ff @(posedge clk) begin
        if (!reset_n)              last <= SEL_D2;
        else if (sel != SEL_IDLE)  last <= sel;
    end
endmodule

// File: rtl/wrbuf_ctrl.sv
// Write-buffer controller: arbitrates three sources into a FIFO and drains it to memory.
module wrbuf_ctrl
    import wrbuf_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [2:0]                 req,
    input  logic [ADDR_W-1:0]          addr0,
    input  logic [ADDR_W-1:0]          addr1,
    input  logic [ADDR_W-1:0]          addr2,
    output logic [2:0]                 grant,
    output logic [1:0]                 WrBuf_sel,
    input  logic [DATA_W-1:0]          wrbuf_din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    input  logic                       mem_ack,
    input  logic                       flush,
    output logic                       flush_done
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] st_addr [DEPTH];
    logic [DATA_W-1:0] st_data [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]     count_nxt;
    logic [ADDR_W-1:0] push_addr, head_addr;
    logic [DATA_W-1:0] head_data;
    logic              push, pop, load, from_nxt, flush_seen;
    drain_state_t      state, state_nxt;

    wrbuf_rr_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .en      (!full && !flush),
        .grant   (grant),
        .sel     (WrBuf_sel)
    );

    always_comb begin
        push = |grant;
        pop  = (state == BUSY) && mem_ack;
        case (WrBuf_sel)
            SEL_D0:  push_addr = addr0;
            SEL_D1:  push_addr = addr1;
            default: push_addr = addr2;
        endcase
        count_nxt = count + CW'(push) - CW'(pop);
        rd_nxt    = rd_ptr + PW'(1);
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        from_nxt  = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                state_nxt = BUSY;
                load      = 1'b1;
            end
            BUSY: if (mem_ack) begin
                if (count_nxt != '0) begin
                    load     = 1'b1;
                    from_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Back-to-back with a single stored entry: the next head is the one being pushed now.
    always_comb begin
        if (from_nxt && push && (wr_ptr == rd_nxt)) begin
            head_addr = push_addr;
            head_data = wrbuf_din;
        end else begin
            head_addr = st_addr[from_nxt ? rd_nxt : rd_ptr];
            head_data = st_data[from_nxt ? rd_nxt : rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            st_addr[wr_ptr] <= push_addr;
            st_data[wr_ptr] <= wrbuf_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            flush_seen <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_nxt;
            count   <= count_nxt;
            full    <= (count_nxt == CW'(DEPTH));
            empty   <= (count_nxt == '0);
            state   <= state_nxt;
            mem_req <= (state_nxt == BUSY);
            if (load) begin
                mem_addr <= head_addr;
                mem_data <= head_data;
            end
            // One pulse per flush assertion, on the first empty-and-idle edge.
            flush_done <= flush && !flush_seen && (state == IDLE) && (count == '0);
            flush_seen <= flush && (flush_seen || ((state == IDLE) && (count == '0)));
        end
    end
endmodule

// File: tb/tb_wrbuf_ctrl.sv
// Randomized scoreboard bench for wrbuf_ctrl against a queue-based reference model.
module tb_wrbuf_ctrl;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 64;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    req = 3'b000;
    logic [AW-1:0] a [3];
    logic [DW-1:0] d [3];
    logic [AW-1:0] addr0, addr1, addr2;
    logic [2:0]    grant;
    logic [1:0]    WrBuf_sel;
    logic [DW-1:0] wrbuf_din;
    logic          full, empty, mem_req, mem_ack = 1'b0, flush = 1'b0, flush_done;
    logic [2:0]    count;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;

    ent_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int   m_last = 2;
    int   m_cnt  = 0;
    bit   m_mreq = 0, m_fseen = 0, m_fdone = 0;

    always #5 clk = ~clk;

    assign addr0 = a[0];
    assign addr1 = a[1];
    assign addr2 = a[2];

    // External 64-bit data mux driven by WrBuf_sel.
    always_comb begin
        case (WrBuf_sel)
            2'b00:   wrbuf_din = d[0];
            2'b01:   wrbuf_din = d[1];
            2'b10:   wrbuf_din = d[2];
            default: wrbuf_din = '0;
        endcase
    end

    wrbuf_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .addr0      (addr0),
        .addr1      (addr1),
        .addr2      (addr2),
        .grant      (grant),
        .WrBuf_sel  (WrBuf_sel),
        .wrbuf_din  (wrbuf_din),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ack    (mem_ack),
        .flush      (flush),
        .flush_done (flush_done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every accepted drain must match the oldest pushed entry.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (reset_n && mem_req && mem_ack) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL drain_unexpected: got addr %0h expected no entry", mem_addr);
                end else begin
                    e = sb.pop_front();
                    chk("drain_addr", 64'(mem_addr), 64'(e.a));
                    chk("drain_data", mem_data, e.d);
                end
            end
        end
    end

    // One clock: check outputs against the model at negedge, then advance the model.
    task automatic step(input bit rst);
        int g;
        int i;
        bit pop;
        int cnt_n;
        bit mreq_n, fdone_n, fseen_n;
        logic [2:0] eg;
        logic [1:0] es;
        g = -1; pop = 0; cnt_n = 0; mreq_n = 0; fdone_n = 0; fseen_n = 0;
        reset_n = !rst;
        if (rst) begin
            mem_ack = 1'b0;
            flush   = 1'b0;
        end
        @(negedge clk);
        if (!rst) begin
            if (m_cnt != DEPTH && !flush)
                for (int k = 1; k <= 3; k++) begin
                    i = (m_last + k) % 3;
                    if (g < 0 && req[i]) g = i;
                end
            eg = (g < 0) ? 3'b000 : 3'(1 << g);
            es = (g < 0) ? 2'b11 : 2'(g);
            chk("grant",      64'(grant),      64'(eg));
            chk("wrbuf_sel",  64'(WrBuf_sel),  64'(es));
            chk("count",      64'(count),      64'(m_cnt));
            chk("full",       64'(full),       64'(m_cnt == DEPTH));
            chk("empty",      64'(empty),      64'(m_cnt == 0));
            chk("mem_req",    64'(mem_req),    64'(m_mreq));
            chk("flush_done", 64'(flush_done), 64'(m_fdone));
            if (g >= 0) begin
                sb.push_back('{a[g], d[g]});
                m_last = g;
            end
            pop     = m_mreq && mem_ack;
            cnt_n   = m_cnt + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
            mreq_n  = m_mreq ? (pop ? (cnt_n != 0) : 1'b1) : (m_cnt != 0);
            fdone_n = flush && !m_fseen && !m_mreq && m_cnt == 0;
            fseen_n = flush && (m_fseen || (!m_mreq && m_cnt == 0));
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_last = 2; m_cnt = 0; m_mreq = 0; m_fseen = 0; m_fdone = 0;
            sb.delete();
            req = 3'b000;
            chk("rst_mem_addr", 64'(mem_addr), 64'd0);
            chk("rst_mem_data", mem_data, 64'd0);
            chk("rst_mem_req",  64'(mem_req), 64'd0);
        end else begin
            m_cnt = cnt_n; m_mreq = mreq_n; m_fdone = fdone_n; m_fseen = fseen_n;
            if (g >= 0) req[g] = 1'b0;
        end
    endtask

    // Requests are raised randomly per enabled source and held until granted.
    task automatic run(input int n, input logic [2:0] mask, input int rq, input int ak, input bit fl);
        repeat (n) begin
            for (int s = 0; s < 3; s++)
                if (mask[s] && !req[s] && $urandom_range(99) < rq) begin
                    a[s]   = $urandom;
                    d[s]   = {$urandom, $urandom};
                    req[s] = 1'b1;
                end
            mem_ack = ($urandom_range(99) < ak);
            flush   = fl;
            step(1'b0);
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            a[s] = '0;
            d[s] = '0;
        end
        step(1'b1);
        step(1'b1);
        // All three requesting from reset: d0, d1, d2 in turn.
        run(3, 3'b111, 100, 0, 1'b0);
        run(10, 3'b000, 0, 100, 1'b0);
        // Fill to full with no acks, then release one ack at a time.
        run(8, 3'b111, 100, 0, 1'b0);
        run(1, 3'b000, 0, 100, 1'b0);
        run(3, 3'b000, 0, 0, 1'b0);
        run(12, 3'b000, 0, 100, 1'b0);
        // Streaming one source with ack every cycle.
        run(20, 3'b001, 100, 100, 1'b0);
        run(10, 3'b000, 0, 100, 1'b0);
        // Flush with entries queued and all sources requesting.
        run(2, 3'b001, 100, 0, 1'b0);
        run(12, 3'b111, 100, 50, 1'b1);
        run(6, 3'b000, 0, 100, 1'b0);
        // Flush raised while already empty and idle.
        run(3, 3'b000, 0, 0, 1'b1);
        run(2, 3'b000, 0, 0, 1'b0);
        // Reset while draining with entries queued.
        run(4, 3'b111, 100, 0, 1'b0);
        step(1'b1);
        run(4, 3'b111, 100, 100, 1'b0);
        // Mixed random traffic with occasional flush windows.
        for (int blk = 0; blk < 25; blk++)
            run(16, 3'b111, $urandom_range(20, 90), $urandom_range(10, 90), $urandom_range(3) == 0);
        run(20, 3'b000, 0, 100, 1'b0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
